// File: rtl/core_stall_ctrl_pkg.sv
// Shared definitions for the fetch stall controller: FSM state encoding and
// default timing constants.
package core_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FLUSH = 2'd2
  } stall_state_t;

  localparam int FLUSH_CYCLES_DEF = 2;
  localparam int TIMEOUT_DEF      = 255;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/core_prio_enc.sv
// Fixed-priority encoder: index of the lowest set bit plus an any-set flag.
module core_prio_enc #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  vec,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IW'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/core_stall_ctrl.sv
// Fetch stall controller: arbitrates stall sources, freezes fetch until the
// served source completes, optionally flushes the front end, and times out.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no source served; stall combinationally on a pending request
//   ST_WAIT  | waiting for done of active_src; other sources ignored
//   ST_FLUSH | front-end flush window, FLUSH_CYCLES long, requests not sampled
module core_stall_ctrl
  import core_stall_ctrl_pkg::*;
#(
  parameter int                  NUM_SRC      = 2,
  parameter logic [NUM_SRC-1:0]  FLUSH_MASK   = NUM_SRC'(1),
  parameter int                  FLUSH_CYCLES = FLUSH_CYCLES_DEF,
  parameter int                  TIMEOUT      = TIMEOUT_DEF,
  parameter int                  STAT_W       = 32,
  localparam int                 SRC_W        = idx_w(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] req,
  input  logic [NUM_SRC-1:0] done,
  input  logic               err_clr,
  output logic               fetch_stall,
  output logic               flush,
  output logic [SRC_W-1:0]   active_src,
  output logic               timeout_err,
  output logic [STAT_W-1:0]  stall_cnt
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam int FCNT_W = $clog2(FLUSH_CYCLES + 1);
  // The IDLE entry cycle already stalls, so the WAIT budget ends one count early.
  localparam logic [WCNT_W-1:0] EXPIRE_AT = (TIMEOUT >= 2) ? WCNT_W'(TIMEOUT - 2) : '0;

  stall_state_t       state, state_nxt;
  logic [SRC_W-1:0]   sel;
  logic               sel_any;
  logic [WCNT_W-1:0]  wait_cnt;
  logic [FCNT_W-1:0]  flush_cnt;
  logic               ld_active;
  logic               wait_inc;
  logic               tmo;

  core_prio_enc #(
    .N  (NUM_SRC),
    .IW (SRC_W)
  ) u_prio (
    .vec (req),
    .idx (sel),
    .any (sel_any)
  );

  always_comb begin
    state_nxt   = state;
    fetch_stall = 1'b0;
    ld_active   = 1'b0;
    wait_inc    = 1'b0;
    tmo         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_any) begin
          if (done[sel]) begin
            if (FLUSH_MASK[sel]) state_nxt = ST_FLUSH;
          end else begin
            fetch_stall = 1'b1;
            ld_active   = 1'b1;
            state_nxt   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (done[active_src]) begin
          state_nxt = FLUSH_MASK[active_src] ? ST_FLUSH : ST_IDLE;
        end else if (!req[active_src]) begin
          state_nxt = ST_IDLE;
        end else begin
          fetch_stall = 1'b1;
          if (wait_cnt >= EXPIRE_AT) begin
            tmo       = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            wait_inc = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        fetch_stall = 1'b1;
        if (flush_cnt == '0) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      flush       <= 1'b0;
      active_src  <= '0;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
      timeout_err <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state <= state_nxt;
      flush <= (state_nxt == ST_FLUSH);

      if (ld_active) begin
        active_src <= sel;
        wait_cnt   <= '0;
      end else if (wait_inc) begin
        wait_cnt <= wait_cnt + WCNT_W'(1);
      end

      if (state != ST_FLUSH && state_nxt == ST_FLUSH)
        flush_cnt <= FCNT_W'(FLUSH_CYCLES - 1);
      else if (state == ST_FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FCNT_W'(1);

      if (tmo)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;

      stall_cnt <= stall_cnt + STAT_W'(fetch_stall);
    end
  end

endmodule

// File: tb/tb_core_stall_ctrl.sv
// Scoreboard bench for core_stall_ctrl: directed per-cycle vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_core_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req = 2'b00;
  logic [1:0] done = 2'b00;
  logic       err_clr = 1'b0;
  logic       fetch_stall;
  logic       flush;
  logic [0:0] active_src;
  logic       timeout_err;
  logic [3:0] stall_cnt;

  core_stall_ctrl #(
    .NUM_SRC      (2),
    .FLUSH_MASK   (2'b01),
    .FLUSH_CYCLES (2),
    .TIMEOUT      (4),
    .STAT_W       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .done        (done),
    .err_clr     (err_clr),
    .fetch_stall (fetch_stall),
    .flush       (flush),
    .active_src  (active_src),
    .timeout_err (timeout_err),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       stall;
    logic       fl;
    logic       err;
    int         src;
    logic [3:0] cnt;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] model_cnt = 4'd0;

  task automatic chk(input string name, input string fld, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d", name, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk(e.name, "fetch_stall", 32'(fetch_stall), 32'(e.stall));
      chk(e.name, "flush", 32'(flush), 32'(e.fl));
      chk(e.name, "timeout_err", 32'(timeout_err), 32'(e.err));
      chk(e.name, "stall_cnt", 32'(stall_cnt), 32'(e.cnt));
      if (e.src >= 0) chk(e.name, "active_src", 32'(active_src), 32'(e.src));
    end
  end

  // Apply one cycle of inputs and queue what the outputs must be in that cycle.
  task automatic step(input logic r, input logic [1:0] rq, input logic [1:0] dn,
                      input logic clr, input logic st, input logic fl,
                      input logic er, input int src, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; req = rq; done = dn; err_clr = clr;
    if (r) model_cnt = 4'd0;
    e.name = name; e.stall = st; e.fl = fl; e.err = er; e.src = src; e.cnt = model_cnt;
    sb_q.push_back(e);
    if (!r && st) model_cnt = model_cnt + 4'd1;
  endtask

  initial begin
    //     rst req    done   clr  stall flush err src name
    step(1, 2'b00, 2'b00, 0,   0,   0,    0,  0, "reset");
    // source 0 waits 3 cycles, completes, flushes for 2
    step(0, 2'b01, 2'b00, 0,   1,   0,    0,  0, "s0_req");
    step(0, 2'b01, 2'b00, 0,   1,   0,    0,  0, "s0_wait1");
    step(0, 2'b01, 2'b00, 0,   1,   0,    0,  0, "s0_wait2");
    step(0, 2'b01, 2'b01, 0,   0,   0,    0,  0, "s0_done");
    step(0, 2'b10, 2'b00, 0,   1,   1,    0,  0, "flush1");
    step(0, 2'b10, 2'b00, 0,   1,   1,    0,  0, "flush2");
    // source 1 waits then aborts
    step(0, 2'b10, 2'b00, 0,   1,   0,    0,  0, "s1_req");
    step(0, 2'b10, 2'b00, 0,   1,   0,    0,  1, "s1_wait");
    step(0, 2'b00, 2'b00, 0,   0,   0,    0,  1, "s1_abort");
    step(0, 2'b00, 2'b00, 0,   0,   0,    0,  1, "abort_noflush");
    // both request, source 0 wins; source 1 then completes without flush
    step(0, 2'b11, 2'b10, 0,   1,   0,    0,  1, "prio_req");
    step(0, 2'b11, 2'b10, 0,   1,   0,    0,  0, "prio_wait0");
    step(0, 2'b11, 2'b01, 0,   0,   0,    0,  0, "prio_done0");
    step(0, 2'b11, 2'b11, 0,   1,   1,    0,  0, "prio_flush1");
    step(0, 2'b11, 2'b11, 0,   1,   1,    0,  0, "prio_flush2");
    step(0, 2'b10, 2'b10, 0,   0,   0,    0,  0, "s1_imm_done");
    step(0, 2'b00, 2'b00, 0,   0,   0,    0,  0, "s1_noflush");
    // timeout on source 1 after 4 stall cycles
    step(0, 2'b10, 2'b00, 0,   1,   0,    0,  0, "to_req");
    step(0, 2'b10, 2'b00, 0,   1,   0,    0,  1, "to_w0");
    step(0, 2'b10, 2'b00, 0,   1,   0,    0,  1, "to_w1");
    step(0, 2'b10, 2'b00, 0,   1,   0,    0,  1, "to_w2");
    step(0, 2'b00, 2'b00, 0,   0,   0,    1,  1, "to_idle");
    step(0, 2'b00, 2'b00, 0,   0,   0,    1,  1, "err_sticky");
    step(0, 2'b00, 2'b00, 1,   0,   0,    1,  1, "err_clr");
    step(0, 2'b00, 2'b00, 0,   0,   0,    0,  1, "err_cleared");
    // timeout with err_clr held: set wins; stall_cnt wraps 15 -> 0
    step(0, 2'b10, 2'b00, 1,   1,   0,    0,  1, "setwin_req");
    step(0, 2'b10, 2'b00, 1,   1,   0,    0,  1, "setwin_w0");
    step(0, 2'b10, 2'b00, 1,   1,   0,    0,  1, "setwin_w1");
    step(0, 2'b10, 2'b00, 1,   1,   0,    0,  1, "setwin_w2");
    step(0, 2'b00, 2'b00, 0,   0,   0,    1,  1, "setwin_err");
    // reset in the middle of a flush
    step(0, 2'b01, 2'b01, 0,   0,   0,    1,  1, "imm_done_flush");
    step(0, 2'b00, 2'b00, 0,   1,   1,    1,  1, "rst_flush1");
    step(1, 2'b00, 2'b00, 0,   0,   0,    0,  0, "rst_mid_flush");
    step(1, 2'b01, 2'b00, 0,   1,   0,    0,  0, "rst_idle_rule");
    step(0, 2'b00, 2'b00, 0,   0,   0,    0,  0, "rst_release");
    step(0, 2'b00, 2'b00, 0,   0,   0,    0,  0, "no_late_flush");

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/core_stall_ctrl.md
CORE_STALL_CTRL -- requirements
Module: core_stall_ctrl

Interface
REQ-001 Parameters (name, default, meaning): NUM_SRC, 2, number of stall sources; index 0 has the highest priority.
REQ-002 Parameters: FLUSH_MASK, 2'b01, bit i=1 means source i requires a front-end flush after completion.
REQ-003 Parameters: FLUSH_CYCLES, 2, length of the flush window in cycles (>=1); TIMEOUT, 255, maximum wait cycles (>=1).
REQ-004 Parameters: STAT_W, 32, width of the stall-cycle counter.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, asynchronous active-high reset.
REQ-007 Port req, input, NUM_SRC, per-source operation pending (branch, memory op, ...).
REQ-008 Port done, input, NUM_SRC, per-source result valid (new PC valid, memory op valid, ...).
REQ-009 Port err_clr, input, 1, clears timeout_err.
REQ-010 Port fetch_stall, output, 1, freezes fetch.
REQ-011 Port flush, output, 1, front-end flush strobe.
REQ-012 Port active_src, output, $clog2(NUM_SRC) (min 1), index of the source being served.
REQ-013 Port timeout_err, output, 1, sticky timeout flag.
REQ-014 Port stall_cnt, output, STAT_W, total cycles with fetch_stall=1.

Function
REQ-015 The block SHALL implement FSM states IDLE, WAIT and FLUSH.
REQ-016 IDLE, sel: sel SHALL be the lowest index with req[i]=1.
REQ-017 IDLE, stall: fetch_stall SHALL be req[sel] & ~done[sel], combinationally in the same cycle, with zero-latency stall.
REQ-018 IDLE, req[sel] & ~done[sel]: the FSM SHALL go to WAIT, latch sel into active_src and clear wait_cnt.
REQ-019 IDLE, req[sel] & done[sel]: the FSM SHALL go to FLUSH if FLUSH_MASK[sel]=1, else stay in IDLE; fetch_stall=0 in that cycle.
REQ-020 WAIT: fetch_stall SHALL be ~done[active_src]; req and done of all other sources SHALL be ignored.
REQ-021 WAIT, done[active_src]=1: the FSM SHALL go to FLUSH if FLUSH_MASK[active_src]=1, else to IDLE.
REQ-022 WAIT, req[active_src]=0 and done=0 (abort): the FSM SHALL return to IDLE with fetch_stall=0 that cycle and no flush.
REQ-023 WAIT, wait_cnt: wait_cnt SHALL increment each WAIT cycle without done.
REQ-024 WAIT, timeout: if wait_cnt reaches TIMEOUT-1 without done, the next cycle SHALL set timeout_err=1 and move the FSM to IDLE.
REQ-025 wait_cnt SHALL be $clog2(TIMEOUT+1) bits wide and SHALL never wrap.
REQ-026 FLUSH: flush=1 and fetch_stall=1 for exactly FLUSH_CYCLES cycles, then IDLE; new requests SHALL wait and not be sampled.
REQ-027 flush SHALL be registered (FSM state decode) and SHALL be 0 outside FLUSH.
REQ-028 timeout_err SHALL stay set until err_clr=1; if timeout and err_clr occur in the same cycle, set SHALL win.
REQ-029 stall_cnt SHALL increment by 1 every cycle fetch_stall=1 and SHALL wrap modulo 2^STAT_W.
REQ-030 active_src SHALL hold its last value in IDLE.

Reset
REQ-031 On rst=1 (asynchronous): state=IDLE, wait_cnt=0, flush cycle counter=0, active_src=0, timeout_err=0, stall_cnt=0, flush=0.
REQ-032 fetch_stall SHALL follow the IDLE rule while in reset.
REQ-033 Reset asserted during WAIT or FLUSH SHALL abort the operation; no flush pulse is emitted after release.

Structure
REQ-034 A shared core package SHALL hold the FSM state enum (stall_state_t) and the default FLUSH_CYCLES and TIMEOUT constants.
REQ-035 The priority selection SHALL be a sub-module core_prio_enc (NUM_SRC-bit one-hot-lowest to index plus any-valid output).

Verification
REQ-036 NUM_SRC=2: req=01, done=00 for 3 cycles, then done=01 -> fetch_stall=1 for 3 cycles, 0 on the done cycle, then flush=1 for 2 cycles with stall=1.
REQ-037 req=11, done=10 -> source 0 served, fetch_stall=1 and active_src=0; on source-0 done, source 1 (mask 0) completes without a flush.
REQ-038 TIMEOUT=4: req=10, done held 0 -> stall for 4 cycles, then timeout_err=1 and IDLE; err_clr clears it.
REQ-039 WAIT on source 1, req drops to 00 -> fetch_stall=0 that cycle, IDLE, no flush.
REQ-040 Reset asserted mid-FLUSH -> flush=0 immediately, stall_cnt=0; after release req=00 -> fetch_stall=0.
REQ-041 STAT_W=4, 17 stall cycles -> stall_cnt=1 (wrap).
